memoria_datos_multimodo: RTL and testbench

MEMORIA_DATOS_MULTIMODO -- requirements
Module: memoria_datos_multimodo

---
 rtl/memoria_datos_pkg.sv | 15 +
 rtl/memoria_datos_clear_fsm.sv | 56 +++++
 rtl/memoria_datos_multimodo.sv | 170 +++++++++++++++++
 tb/tb_memoria_datos_multimodo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/memoria_datos_pkg.sv
// Shared definitions for the multimode data memory: clear-FSM state encoding
// and the accepted values of the latency and collision mode parameters.
package memoria_datos_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   localparam string PERF_LOW_LATENCY      = "LOW_LATENCY";
   localparam string PERF_HIGH_PERFORMANCE = "HIGH_PERFORMANCE";
   localparam string WM_READ_FIRST         = "READ_FIRST";
   localparam string WM_WRITE_FIRST        = "WRITE_FIRST";

endpackage

// File: rtl/memoria_datos_clear_fsm.sv
// Zero-fill sequencer: sweeps every word address once after reset or on a
// clear request, flagging busy for the duration of the sweep.
module memoria_datos_clear_fsm
   import memoria_datos_pkg::*;
#(
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_req,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  clr_we
);

   clr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Clear requests seen while already sweeping are ignored (no restart).
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (32'(clr_cnt_q) == RAM_DEPTH - 1) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
      endcase
   end

   assign busy     = (state_q == ST_CLEAR);
   assign clr_we   = (state_q == ST_CLEAR);
   assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/memoria_datos_multimodo.sv
// Single-port-write / synchronous-read data memory with per-byte enables,
// selectable read latency and collision policy, and a full-array zero-fill sweep.
module memoria_datos_multimodo
   import memoria_datos_pkg::*;
#(
   parameter int unsigned RAM_WIDTH       = 16,
   parameter int unsigned BYTE_WIDTH      = 8,
   parameter int unsigned RAM_DEPTH       = 1024,
   parameter int unsigned ADDR_WIDTH      = 11,
   parameter string       RAM_PERFORMANCE = PERF_LOW_LATENCY,
   parameter string       WRITE_MODE      = WM_READ_FIRST
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [ADDR_WIDTH-1:0]             i_addr,
   input  logic [RAM_WIDTH-1:0]              i_data,
   input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]   i_wea,
   input  logic                              i_rea,
   input  logic                              i_clear,
   output logic [RAM_WIDTH-1:0]              o_data,
   output logic                              o_valid,
   output logic                              o_busy
);

   localparam int unsigned NUM_BYTES   = RAM_WIDTH / BYTE_WIDTH;
   localparam int unsigned MEM_AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam bit          HIGH_PERF   = (RAM_PERFORMANCE == PERF_HIGH_PERFORMANCE);
   localparam bit          WRITE_FIRST = (WRITE_MODE == WM_WRITE_FIRST);

   logic                  busy;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  clr_we;

   memoria_datos_clear_fsm #(
      .RAM_DEPTH  (RAM_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_fsm (
      .clk       (i_clk),
      .rst_n     (i_reset),
      .clear_req (i_clear),
      .busy      (busy),
      .clr_addr  (clr_addr),
      .clr_we    (clr_we)
   );

   logic                 in_range_c;
   logic                 rd_acc_c;
   logic [MEM_AW-1:0]    rd_idx_c;
   logic [MEM_AW-1:0]    wr_idx_c;
   logic [NUM_BYTES-1:0] wr_be_c;
   logic [RAM_WIDTH-1:0] wr_data_c;

   // Write port is shared between the clear sweep and user writes.
   always_comb begin
      in_range_c = (32'(i_addr) < RAM_DEPTH);
      rd_acc_c   = i_rea & ~busy;
      rd_idx_c   = MEM_AW'(i_addr);
      wr_idx_c   = rd_idx_c;
      wr_be_c    = in_range_c ? i_wea : '0;
      wr_data_c  = i_data;
      if (clr_we) begin
         wr_idx_c  = MEM_AW'(clr_addr);
         wr_be_c   = '1;
         wr_data_c = '0;
      end
   end

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_dout;

   always_ff @(posedge i_clk) begin
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
         if (wr_be_c[k]) begin
            mem[wr_idx_c][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_c[k*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      if (rd_acc_c) begin
         ram_dout <= mem[rd_idx_c];
      end
   end

   logic                 rd_vld1_q, rd_vld1_d;
   logic                 rd_oor_q, rd_oor_d;
   logic [NUM_BYTES-1:0] fwd_be_q, fwd_be_d;
   logic [RAM_WIDTH-1:0] fwd_data_q, fwd_data_d;
   logic [RAM_WIDTH-1:0] rd1_word_c;

   // Write-first lanes are forwarded around the array rather than re-read.
   always_comb begin
      rd_vld1_d  = rd_acc_c;
      rd_oor_d   = ~in_range_c;
      fwd_be_d   = (WRITE_FIRST && rd_acc_c) ? wr_be_c : '0;
      fwd_data_d = i_data;
      rd1_word_c = '0;
      for (int unsigned k = 0; k < NUM_BYTES; k++) begin
         rd1_word_c[k*BYTE_WIDTH +: BYTE_WIDTH] = fwd_be_q[k] ? fwd_data_q[k*BYTE_WIDTH +: BYTE_WIDTH]
                                                              : ram_dout[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (rd_oor_q) begin
         rd1_word_c = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rd_vld1_q  <= 1'b0;
         rd_oor_q   <= 1'b0;
         fwd_be_q   <= '0;
         fwd_data_q <= '0;
      end else begin
         rd_vld1_q  <= rd_vld1_d;
         rd_oor_q   <= rd_oor_d;
         fwd_be_q   <= fwd_be_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   logic                 out_vld_c;
   logic [RAM_WIDTH-1:0] out_word_c;

   if (HIGH_PERF) begin : g_hp
      logic                 p2_vld_q, p2_vld_d;
      logic [RAM_WIDTH-1:0] p2_data_q, p2_data_d;

      always_comb begin
         p2_vld_d  = rd_vld1_q;
         p2_data_d = rd_vld1_q ? rd1_word_c : p2_data_q;
      end

      always_ff @(posedge i_clk or negedge i_reset) begin
         if (!i_reset) begin
            p2_vld_q  <= 1'b0;
            p2_data_q <= '0;
         end else begin
            p2_vld_q  <= p2_vld_d;
            p2_data_q <= p2_data_d;
         end
      end

      assign out_vld_c  = p2_vld_q;
      assign out_word_c = p2_data_q;
   end else begin : g_ll
      assign out_vld_c  = rd_vld1_q;
      assign out_word_c = rd1_word_c;
   end

   logic                 o_valid_q, o_valid_d;
   logic [RAM_WIDTH-1:0] o_data_q, o_data_d;

   // Output register keeps the last returned word between valid pulses.
   always_comb begin
      o_valid_d = out_vld_c;
      o_data_d  = out_vld_c ? out_word_c : o_data_q;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
      end
   end

   assign o_data  = o_data_q;
   assign o_valid = o_valid_q;
   assign o_busy  = busy;

endmodule

// File: tb/tb_memoria_datos_multimodo.sv
// Scoreboard bench for memoria_datos_multimodo: directed reads push expected
// word and arrival edge; a negedge monitor pops and compares on every o_valid.
module tb_memoria_datos_multimodo;

   localparam string PERF  = "LOW_LATENCY";
   localparam string WMODE = "READ_FIRST";
   localparam int    LAT   = (PERF == "HIGH_PERFORMANCE") ? 2 : 1;

   logic        clk;
   logic        rst_n;
   logic [10:0] addr;
   logic [15:0] data;
   logic [1:0]  wea;
   logic        rea;
   logic        clr;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_busy;

   typedef struct {
      logic [15:0] word;
      int          edge_no;
   } exp_t;

   exp_t sb_q[$];
   int   total    = 0;
   int   bad      = 0;
   int   edge_cnt = 0;

   memoria_datos_multimodo #(
      .RAM_WIDTH       (16),
      .BYTE_WIDTH      (8),
      .RAM_DEPTH       (1024),
      .ADDR_WIDTH      (11),
      .RAM_PERFORMANCE (PERF),
      .WRITE_MODE      (WMODE)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .i_addr  (addr),
      .i_data  (data),
      .i_wea   (wea),
      .i_rea   (rea),
      .i_clear (clr),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && o_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'(o_valid), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("rd_data", 32'(o_data), 32'(e.word));
            check("rd_latency_edge", 32'(edge_cnt), 32'(e.edge_no));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] w);
      addr = a; data = d; wea = w;
      tick();
      wea = 2'b00;
   endtask

   task automatic rd(input logic [10:0] a, input logic [15:0] exp);
      addr = a; rea = 1'b1;
      sb_q.push_back('{exp, edge_cnt + 1 + LAT});
      tick();
      rea = 1'b0;
   endtask

   task automatic wr_rd(input logic [10:0] a, input logic [15:0] d, input logic [1:0] w,
                        input logic [15:0] exp);
      addr = a; data = d; wea = w; rea = 1'b1;
      sb_q.push_back('{exp, edge_cnt + 1 + LAT});
      tick();
      wea = 2'b00; rea = 1'b0;
   endtask

   task automatic drain();
      repeat (LAT + 2) tick();
   endtask

   task automatic measure_busy(output int n);
      n = 0;
      while (o_busy && n < 2000) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0; addr = '0; data = '0; wea = '0; rea = 1'b0; clr = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(o_busy), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_data", 32'(o_data), 32'd0);

      rst_n = 1'b1;
      measure_busy(n);
      check("busy_len_after_reset", 32'(n), 32'd1024);
      rd(11'd5, 16'h0000);
      drain();

      wr(11'd0, 16'h000F, 2'b11);
      rd(11'd0, 16'h000F);
      drain();
      check("hold_data", 32'(o_data), 32'h000F);
      check("hold_valid", 32'(o_valid), 32'd0);

      wr(11'd1, 16'h1234, 2'b11);
      wr(11'd1, 16'hABCD, 2'b01);
      rd(11'd1, 16'h12CD);
      wr(11'd1, 16'h5600, 2'b10);
      rd(11'd1, 16'h56CD);

      wr(11'd2, 16'h0001, 2'b11);
      wr_rd(11'd2, 16'h0002, 2'b11, (WMODE == "WRITE_FIRST") ? 16'h0002 : 16'h0001);
      rd(11'd2, 16'h0002);
      drain();

      rd(11'd0, 16'h000F);
      rd(11'd1, 16'h56CD);
      rd(11'd2, 16'h0002);
      drain();

      wr(11'h400, 16'hFFFF, 2'b11);
      wr(11'h7FF, 16'hFFFF, 2'b11);
      rd(11'h400, 16'h0000);
      rd(11'h7FF, 16'h0000);
      rd(11'd0, 16'h000F);
      wr(11'd1023, 16'hBEEF, 2'b11);
      rd(11'd1023, 16'hBEEF);
      drain();

      addr = 11'd0; rea = 1'b1; clr = 1'b1;
      sb_q.push_back('{16'h000F, edge_cnt + 1 + LAT});
      tick();
      rea = 1'b0; clr = 1'b0;
      check("busy_after_clear", 32'(o_busy), 32'd1);
      n = 0;
      while (o_busy && n < 2000) begin
         if (n == 1) begin
            addr = 11'd3; data = 16'h7777; wea = 2'b11; rea = 1'b1;
         end else begin
            wea = 2'b00; rea = 1'b0;
         end
         clr = (n == 500);
         tick();
         n++;
      end
      wea = 2'b00; rea = 1'b0; clr = 1'b0;
      check("busy_len_clear", 32'(n), 32'd1024);
      rd(11'd0, 16'h0000);
      rd(11'd1, 16'h0000);
      rd(11'd3, 16'h0000);
      rd(11'd1023, 16'h0000);
      drain();

      wr(11'd4, 16'h4444, 2'b11);
      rd(11'd4, 16'h4444);
      drain();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (300) tick();
      rst_n = 1'b0;
      #1;
      check("midclear_rst_busy", 32'(o_busy), 32'd1);
      check("midclear_rst_valid", 32'(o_valid), 32'd0);
      check("midclear_rst_data", 32'(o_data), 32'd0);
      tick();
      rst_n = 1'b1;
      measure_busy(n);
      check("busy_len_after_midclear_reset", 32'(n), 32'd1024);
      rd(11'd4, 16'h0000);
      rd(11'd0, 16'h0000);
      drain();

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
